// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory line port between icache refill and dcache
// refill/write-back; one fixed-latency transaction in flight, latency counted down here.
module mem_arbiter #(
  parameter int LATENCY = 9,
  parameter int LINE_W  = 128,
  parameter int ADDR_W  = 28
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  // state  | meaning
  // S_IDLE | sample requests, latch winner, load latency count
  // S_BUSY | memory access active, count down to the final cycle
  // S_DONE | one-cycle ack to the granted port, update round-robin pointer
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic              r_gnt_d;
  logic              r_last_d;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;
  logic              w_any_req;
  logic              w_pick_d;

  assign w_any_req = i_req | d_req;
  // D wins alone, or on a tie when I was granted last.
  assign w_pick_d  = d_req & (~i_req | ~r_last_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    mem_en = 1'b0;
    mem_we = 1'b0;
    i_ack  = 1'b0;
    d_ack  = 1'b0;
    busy   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_next = S_BUSY;
      end
      S_BUSY: begin
        mem_en = 1'b1;
        mem_we = r_we;
        busy   = 1'b1;
        if (r_cnt == 4'd0) w_next = S_DONE;
      end
      S_DONE: begin
        i_ack  = ~r_gnt_d;
        d_ack  = r_gnt_d;
        busy   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_gnt_d   <= 1'b0;
      r_last_d  <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt_d <= w_pick_d;
            r_addr  <= w_pick_d ? d_addr : i_addr;
            r_we    <= w_pick_d & d_we;
            r_wdata <= w_pick_d ? d_wdata : '0;
            r_cnt   <= CNT_LOAD;
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else if (!r_we) begin
            if (r_gnt_d) r_d_rdata <= mem_rdata;
            else         r_i_rdata <= mem_rdata;
          end
        end
        S_DONE: r_last_d <= r_gnt_d;
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;

endmodule
